// File: rtl/plic_gateway.sv
// plic_gateway: per-source interrupt gateway in front of the PLIC core.
// Synchronises raw interrupt lines, turns level or rising-edge events into a
// single pending request per source, and holds the source off until the
// core's claim/complete handshake retires that request. Edge sources queue
// further events in a saturating counter while a request is outstanding.
//
// Ports:
//   clk            clock
//   rst            asynchronous active-low reset
//   source         raw asynchronous interrupt lines, bit i = source i
//   edge_mode      per source: 1 = rising-edge, 0 = level-high triggered
//   claim_valid    core claims source claim_id this cycle
//   claim_id       claimed source ID
//   complete_valid core completes source complete_id this cycle
//   complete_id    completed source ID
//   pending        request to core, bit i high while source i is pending
//   active         bit i high while source i is claimed and not completed
//   overflow       one-cycle pulse when an edge is dropped on a full counter
// Source 0 is reserved and has no gateway logic.

module plic_gateway #(
    parameter int unsigned NUM_SOURCES = 128,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 4,
    parameter int unsigned IDW         = $clog2(NUM_SOURCES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SOURCES-1:0] source,
    input  logic [NUM_SOURCES-1:0] edge_mode,
    input  logic                   claim_valid,
    input  logic [IDW-1:0]         claim_id,
    input  logic                   complete_valid,
    input  logic [IDW-1:0]         complete_id,
    output logic [NUM_SOURCES-1:0] pending,
    output logic [NUM_SOURCES-1:0] active,
    output logic [NUM_SOURCES-1:0] overflow
);

    // One-hot-ish encoding so pending/active come straight off state flops.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_PEND   = 2'b01,
        ST_ACTIVE = 2'b10
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Reserved source 0: outputs tied low, inputs intentionally unused.
    logic unused_src0;
    assign unused_src0 = source[0] ^ edge_mode[0];
    assign pending[0]  = 1'b0;
    assign active[0]   = 1'b0;
    assign overflow[0] = 1'b0;

    for (genvar i = 1; i < NUM_SOURCES; i++) begin : g_src
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   s;
        logic                   s_d_q;
        logic                   rise;
        logic                   trig;
        logic                   consume;
        logic                   claim_hit;
        logic                   complete_hit;
        state_e                 state_q;
        state_e                 state_d;
        logic [CNT_WIDTH-1:0]   cnt_q;
        logic [CNT_WIDTH-1:0]   cnt_d;
        logic                   ovf_q;
        logic                   ovf_d;

        // Input synchroniser plus one delay flop for rising-edge detection.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                sync_q <= '0;
                s_d_q  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], source[i]};
                s_d_q  <= s;
            end
        end

        assign s    = sync_q[SYNC_STAGES-1];
        assign rise = s & ~s_d_q;

        // IDs 0 and out-of-range IDs never match any built source.
        assign claim_hit    = claim_valid    && (claim_id    == IDW'(i));
        assign complete_hit = complete_valid && (complete_id == IDW'(i));

        assign trig    = edge_mode[i] ? (rise | (cnt_q != '0)) : s;
        assign consume = (state_q == ST_IDLE) && trig;

        // Next-state, edge counter and overflow decode.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            ovf_d   = 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (trig) state_d = ST_PEND;
                end
                ST_PEND: begin
                    // A same-cycle complete for this ID is ignored here.
                    if (claim_hit) state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (complete_hit) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase

            if (!edge_mode[i]) begin
                cnt_d = '0;
            end else if (consume) begin
                // A queued event is used up; a simultaneous rise replaces it.
                if ((cnt_q != '0) && !rise) cnt_d = cnt_q - CNT_WIDTH'(1);
            end else if (rise) begin
                if (cnt_q == CNT_MAX) ovf_d = 1'b1;
                else                  cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end

        // Gateway state, counter and overflow registers.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                ovf_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                ovf_q   <= ovf_d;
            end
        end

        assign pending[i]  = state_q[0];
        assign active[i]   = state_q[1];
        assign overflow[i] = ovf_q;
    end

endmodule

// File: doc/plic_gateway.md
Name: plic_gateway

Overview:
- Per-source interrupt gateway directly upstream of the plic core.
- Synchronises raw asynchronous interrupt lines and converts level or edge events into single pending requests.
- Holds each source off until the core's claim/complete handshake retires the outstanding request.
- Edge sources queue events in a saturating counter so no edge is lost while a request is in flight.

Parameters:
- NUM_SOURCES, 128, number of interrupt sources including reserved source 0.
- SYNC_STAGES, 2, synchroniser flop depth (>=2).
- CNT_WIDTH, 4, width of the per-source edge event counter.
- IDW, $clog2(NUM_SOURCES), source ID width.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset; all state cleared while low.
- source  in  NUM_SOURCES  raw asynchronous interrupt lines; bit i = source i.
- edge_mode  in  NUM_SOURCES  1 = rising-edge triggered, 0 = level (high) triggered.
- claim_valid  in  1  core claimed source claim_id this cycle.
- claim_id  in  IDW  claimed source ID.
- complete_valid  in  1  core completed source complete_id this cycle.
- complete_id  in  IDW  completed source ID.
- pending  out  NUM_SOURCES  request to core; bit i high while source i is in PEND.
- active  out  NUM_SOURCES  bit i high while source i is in ACTIVE (claimed, not completed).
- overflow  out  NUM_SOURCES  one-cycle pulse when an edge is dropped because the counter is saturated.

Behaviour:
- Reset (rst low, async): synchronisers, delayed-sync flops, counters cleared; every FSM in IDLE; pending, active and overflow all 0. A reset mid-request drops the request and all queued edges.
- Source 0 is reserved: pending[0], active[0] and overflow[0] are constant 0; its FSM and counter are not built.
- Sync: s[i] is source[i] after SYNC_STAGES flops. s_d[i] is s[i] delayed by one flop. rise[i] = s[i] & ~s_d[i].
- Per-source FSM states: IDLE, PEND, ACTIVE.
  - IDLE -> PEND when trig. Level mode: trig = s[i]. Edge mode: trig = rise[i] | (cnt[i] != 0).
  - PEND -> ACTIVE when claim_valid and claim_id == i.
  - ACTIVE -> IDLE when complete_valid and complete_id == i.
  - Level trig is evaluated again in IDLE the cycle after completion, so a still-high line re-requests 1 cycle after completion.
- Latency: raw source change to pending high = SYNC_STAGES+1 cycles (3 at default); registered output, no combinational path from inputs to outputs.
- Level mode: deassertion while in PEND or ACTIVE does not withdraw the request; pending holds until claimed.
- Edge counter, edge mode only:
  - On rise, when the edge is not consumed by IDLE->PEND: cnt increments.
  - IDLE->PEND consumes one event. If caused by a rise with cnt == 0, cnt stays 0. If cnt != 0, cnt decrements unless a rise occurs in the same cycle, in which case cnt is unchanged.
  - Saturation: cnt == 2^CNT_WIDTH-1 and a rise that is not consumed -> cnt unchanged, overflow[i] pulses 1 cycle.
  - While edge_mode[i] == 0, cnt[i] is forced to 0.
- Ignored handshakes:
  - A claim for a source in IDLE or ACTIVE.
  - A complete for a source not in ACTIVE.
  - Any ID of 0 or >= NUM_SOURCES.
- Claim and complete in the same cycle:
  - Same ID while in PEND: only the claim takes effect (-> ACTIVE).
  - Different IDs: both are processed independently.
- A mode change takes effect on the next FSM evaluation. It does not abort PEND or ACTIVE.

Test Plan:
- Level: source[5] held high from cycle 0 -> pending[5]=1 at cycle 3. Claim id 5 at cycle 6 -> active[5]=1, pending[5]=0 at cycle 7. Complete id 5 at cycle 10 with line still high -> active[5]=0 at cycle 11, pending[5]=1 at cycle 12.
- Level pulse: source[7] high for 4 cycles then low -> pending[7] rises at cycle 3 and stays 1 until claimed; after completion with line low, pending stays 0.
- Edge queueing: edge_mode[9]=1; 3 rising edges 4 cycles apart -> pending[9] once, cnt=2. Each claim/complete cycle re-raises pending; exactly 3 claims are served, then pending stays 0.
- Saturation: CNT_WIDTH=4, source 9 held ACTIVE, 17 edges -> cnt saturates at 15 after the first edge is consumed by the request; overflow[9] pulses once, on the 17th edge.
- Illegal handshakes: claim id 0, claim id 3 while IDLE, complete id 5 while PEND -> no state or output change. Same-cycle claim+complete id 5 in PEND -> ACTIVE.
- Reset mid-operation: sources 5 ACTIVE and 9 with cnt=4, assert rst low asynchronously mid-cycle -> pending, active and overflow are 0 immediately. After release, no request appears unless the lines re-trigger.
